// File: rtl/div_share_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_share_pkg
// Brief    : Shared types and defaults for the round-robin divider scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package div_share_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned DW_DEF   = 4;
    localparam int unsigned VW_DEF   = 5;
    localparam int unsigned IDW_DEF  = 2;

    // Quotient reported on divide-by-zero; sliced to DW by the user.
    localparam logic [31:0] DZ_QUO_ONES = '1;

endpackage : div_share_pkg
`default_nettype wire

// File: rtl/div_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : div_rr_arb
// Brief    : NREQ-way round-robin grant, first request at or after the pointer.
// Revision : 1.0 - initial release
// ============================================================================
module div_rr_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            gnt_any
);

    logic [IDW:0] pos;
    logic         found;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        pos     = '0;
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + (IDW+1)'(k);
            if (pos >= (IDW+1)'(NREQ)) begin
                pos = pos - (IDW+1)'(NREQ);
            end
            if (req[pos[IDW-1:0]]) begin
                gnt_idx = pos[IDW-1:0];
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        gnt     = '0;
        gnt_any = en & found;
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule : div_rr_arb
`default_nettype wire

// File: rtl/div_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : div_share_sched
// Brief    : Round-robin scheduler sharing one non-restoring sequential divider.
// Revision : 1.0 - initial release
// ============================================================================
module div_share_sched
    import div_share_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned VW   = VW_DEF,
    parameter int unsigned IDW  = IDW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*DW-1:0] req_dividend,
    input  logic [NREQ*VW-1:0] req_divisor,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [DW-1:0]     rsp_quo,
    output logic [VW-1:0]     rsp_rem,
    output logic              rsp_dz,
    output logic              busy
);

    localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [DW-1:0]   q_q, q_d;
    logic [VW:0]     m_q, m_d;
    logic [VW:0]     acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   rsp_quo_q, rsp_quo_d;
    logic [VW-1:0]   rsp_rem_q, rsp_rem_d;
    logic            rsp_dz_q, rsp_dz_d;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            hs;
    logic            arb_en;
    logic [DW-1:0]   sel_dvd;
    logic [VW-1:0]   sel_dvs;
    logic [VW:0]     acc_sh;
    logic [VW:0]     acc_n;
    logic [VW:0]     acc_fix;

    div_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (hs)
    );

    always_comb begin
        sel_dvd = '0;
        sel_dvs = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_dvd = req_dividend[i*DW +: DW];
                sel_dvs = req_divisor[i*VW +: VW];
            end
        end
    end

    // One non-restoring step: shift {acc,q}, then add or subtract by the pre-shift sign.
    assign acc_sh  = {acc_q[VW-1:0], q_q[DW-1]};
    assign acc_n   = acc_q[VW] ? (acc_sh + m_q) : (acc_sh - m_q);
    assign acc_fix = acc_q[VW] ? (acc_q + m_q) : acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            q_q       <= '0;
            m_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            rsp_quo_q <= '0;
            rsp_rem_q <= '0;
            rsp_dz_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            q_q       <= q_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            rsp_quo_q <= rsp_quo_d;
            rsp_rem_q <= rsp_rem_d;
            rsp_dz_q  <= rsp_dz_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        q_d       = q_q;
        m_d       = m_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        rsp_quo_d = rsp_quo_q;
        rsp_rem_d = rsp_rem_q;
        rsp_dz_d  = rsp_dz_q;
        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    id_d  = gnt_idx;
                    ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                    q_d   = sel_dvd;
                    m_d   = {1'b0, sel_dvs};
                    acc_d = '0;
                    cnt_d = '0;
                    if (sel_dvs == '0) begin
                        rsp_quo_d = DZ_QUO_ONES[DW-1:0];
                        rsp_rem_d = VW'(sel_dvd);
                        rsp_dz_d  = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        state_d   = S_RUN;
                    end
                end
            end
            S_RUN: begin
                acc_d = acc_n;
                q_d   = {q_q[DW-2:0], ~acc_n[VW]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                acc_d     = acc_fix;
                rsp_quo_d = q_q;
                rsp_rem_d = acc_fix[VW-1:0];
                rsp_dz_d  = 1'b0;
                state_d   = S_DONE;
            end
            S_DONE: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        arb_en    = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        rsp_valid = (state_q == S_DONE);
        req_ready = gnt;
        rsp_id    = id_q;
        rsp_quo   = rsp_quo_q;
        rsp_rem   = rsp_rem_q;
        rsp_dz    = rsp_dz_q;
    end

endmodule : div_share_sched
`default_nettype wire
